dvi_timing_generator: RTL
=========================

Name: dvi_timing_generator

Overview:
Parametrised successor to the fixed 800x600 timing controller. Generates raster timing for any mode set by parameters: per-axis active, front porch, sync and back porch widths, sync polarity and counter width. Adds registered outputs, multi-bit pixel coordinates, a pixel-enable stall input, and line/frame start strobes. Sits between the pixel clock domain and the pixel source / TMDS encoder in the DVI output path.

Parameters:
CW, 12, counter width for h/v counts and pixel_x/pixel_y; H_TOTAL and V_TOTAL must be <= 2^CW.
H_ACTIVE, 800, active pixels per line.
H_FP, 40, horizontal front porch in pixels.
H_SYNC, 128, hsync width in pixels.
H_BP, 88, horizontal back porch in pixels.
V_ACTIVE, 600, active lines per frame.
V_FP, 1, vertical front porch in lines.
V_SYNC, 4, vsync width in lines.
V_BP, 23, vertical back porch in lines.
H_SYNC_POL, 1, hsync asserted level: 1 = active-high, 0 = active-low.
V_SYNC_POL, 1, vsync asserted level.
FC_W, 8, frame counter width (optional feature only).

Ports:
pixel_clk  input  1  pixel clock; all state on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
enable  input  1  advance timing this cycle; 0 = stall, all state holds.
pixel_x  output  CW  registered horizontal count.
pixel_y  output  CW  registered vertical count.
h_blank  output  1  1 when pixel_x >= H_ACTIVE.
v_blank  output  1  1 when pixel_y >= V_ACTIVE.
h_sync  output  1  hsync at the polarity set by H_SYNC_POL.
v_sync  output  1  vsync at the polarity set by V_SYNC_POL.
dataenable  output  1  ~h_blank & ~v_blank.
line_start  output  1  one-cycle strobe for coordinate h=0 (any line).
frame_start  output  1  one-cycle strobe for coordinate h=0, v=0.

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Internal counters h_cnt and v_cnt, both CW bits.
- Every enabled edge, all outputs are registered decodes of the current (h_cnt, v_cnt), and the counters advance on that same edge. Output latency is therefore 1 enabled cycle behind the counter.
- Counter advance:
  - h_cnt == H_TOTAL-1: h_cnt <= 0.
  - otherwise: h_cnt <= h_cnt+1.
  - v_cnt increments only when h_cnt wraps.
  - v_cnt == V_TOTAL-1 at an h_cnt wrap: v_cnt <= 0.
  - Exact wrap compares only; no >= compares.
- Decode (with h = h_cnt, v = v_cnt):
  - h_sync asserted when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - v_sync asserted when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC. v_sync changes only at line boundaries.
  - Active region is strictly h < H_ACTIVE and v < V_ACTIVE. Exactly H_ACTIVE x V_ACTIVE dataenable cycles per frame.
- pixel_x/pixel_y present raw counts, including during blanking.
- enable=0: counters and every output, strobes included, hold their values. A strobe held high stays high but represents one position.
- Reset (asynchronous, immediate on reset_n low):
  - h_cnt=v_cnt=0, pixel_x=pixel_y=0.
  - h_blank=v_blank=0, dataenable=0.
  - h_sync=~H_SYNC_POL, v_sync=~V_SYNC_POL.
  - line_start=frame_start=0.
- First enabled edge after reset_n release outputs coordinate (0,0): dataenable=1, line_start=1, frame_start=1.
- Reset mid-frame abandons the frame. There is no partial-frame recovery.

Optional Feature:
DVI_TIMING_FRAME_COUNT_EN
- Defined: adds output frame_count [FC_W-1:0].
  - Reset value is 0.
  - Increments on the same enabled edge that registers frame_start=1, except the first frame after reset, which stays 0.
  - Wraps from 2^FC_W-1 to 0.
  - Holds while enable=0.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
All tests use the small mode H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1, H_SYNC_POL=0, V_SYNC_POL=1, CW=5. This gives H_TOTAL=16, V_TOTAL=8 and a 128-cycle frame.
1. Release reset_n with enable=1 -> first edge: pixel_x=0, pixel_y=0, dataenable=1, frame_start=1, line_start=1. Next edge: pixel_x=1, both strobes 0.
2. Run one line -> dataenable high for exactly 8 cycles (x=0..7). h_sync low exactly for x=10..12 and high elsewhere. line_start repeats every 16 cycles.
3. Run 2 frames -> v_sync high for y=5..6 (32 cycles). dataenable never high for y=4..7. frame_start period is 128 cycles, with 32 dataenable cycles per frame.
4. Drop enable for 5 cycles when pixel_x=5 -> all outputs frozen at x=5. First enabled edge after resume gives x=6. Frame period becomes 133 cycles.
5. Assert reset_n low at x=11, y=5 -> outputs go to reset values asynchronously, before the next edge: h_sync=1, v_sync=0, dataenable=0. After release, output restarts at (0,0) with frame_start=1.
6. With DVI_TIMING_FRAME_COUNT_EN and FC_W=2, run 5 frames -> frame_count reads 0,1,2,3,0 at successive frame_start strobes.

Source files
------------

// File: rtl/dvi_timing_generator.sv
`default_nettype none
// ============================================================================
// Module   : dvi_timing_generator
// Brief    : Parametrised raster timing generator with registered outputs,
//            pixel-enable stall and line/frame start strobes. Optional frame
//            counter enabled by defining DVI_TIMING_FRAME_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dvi_timing_generator #(
    parameter int CW         = 12,
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BP       = 88,
    parameter int V_ACTIVE   = 600,
    parameter int V_FP       = 1,
    parameter int V_SYNC     = 4,
    parameter int V_BP       = 23,
    parameter int H_SYNC_POL = 1,
    parameter int V_SYNC_POL = 1,
    parameter int FC_W       = 8
) (
    input  logic          pixel_clk,
    input  logic          reset_n,
    input  logic          enable,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          h_blank,
    output logic          v_blank,
    output logic          h_sync,
    output logic          v_sync,
    output logic          dataenable,
    output logic          line_start,
`ifdef DVI_TIMING_FRAME_COUNT_EN
    output logic [FC_W-1:0] frame_count,
`endif
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CW1     = CW + 1;

    // Decode thresholds carry one extra bit so sync end == 2^CW still compares correctly
    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW:0]   H_ACT   = CW1'(H_ACTIVE);
    localparam logic [CW:0]   V_ACT   = CW1'(V_ACTIVE);
    localparam logic [CW:0]   H_SS    = CW1'(H_ACTIVE + H_FP);
    localparam logic [CW:0]   H_SE    = CW1'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0]   V_SS    = CW1'(V_ACTIVE + V_FP);
    localparam logic [CW:0]   V_SE    = CW1'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HS_ON   = (H_SYNC_POL != 0);
    localparam logic          VS_ON   = (V_SYNC_POL != 0);

    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic [CW-1:0] pixel_x_q, pixel_y_q;
    logic          h_blank_q, h_blank_d;
    logic          v_blank_q, v_blank_d;
    logic          h_sync_q, h_sync_d;
    logic          v_sync_q, v_sync_d;
    logic          de_q, de_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          h_wrap;
    logic [CW:0]   h_ext, v_ext;

    assign h_ext  = {1'b0, h_cnt_q};
    assign v_ext  = {1'b0, v_cnt_q};
    assign h_wrap = (h_cnt_q == H_LAST);

    always_comb begin
        h_cnt_d       = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d       = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
        h_blank_d     = (h_ext >= H_ACT);
        v_blank_d     = (v_ext >= V_ACT);
        h_sync_d      = ((h_ext >= H_SS) && (h_ext < H_SE)) ? HS_ON : ~HS_ON;
        v_sync_d      = ((v_ext >= V_SS) && (v_ext < V_SE)) ? VS_ON : ~VS_ON;
        de_d          = ~h_blank_d & ~v_blank_d;
        line_start_d  = (h_cnt_q == '0);
        frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            h_blank_q     <= 1'b0;
            v_blank_q     <= 1'b0;
            h_sync_q      <= ~HS_ON;
            v_sync_q      <= ~VS_ON;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (enable) begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pixel_x_q     <= h_cnt_q;
            pixel_y_q     <= v_cnt_q;
            h_blank_q     <= h_blank_d;
            v_blank_q     <= v_blank_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign h_blank     = h_blank_q;
    assign v_blank     = v_blank_q;
    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign dataenable  = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef DVI_TIMING_FRAME_COUNT_EN
    // The first frame after reset keeps count 0; later frame starts increment
    logic            seen_frame_q;
    logic [FC_W-1:0] frame_count_q;

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            seen_frame_q  <= 1'b0;
            frame_count_q <= '0;
        end else if (enable && frame_start_d) begin
            seen_frame_q <= 1'b1;
            if (seen_frame_q) begin
                frame_count_q <= frame_count_q + 1'b1;
            end
        end
    end

    assign frame_count = frame_count_q;
`endif

endmodule
`default_nettype wire
